// File: rtl/secded_pkg.sv
// Shared constants and helpers for the SECDED stream decoder: widths derived from
// the Hamming parity count, data-to-codeword position map, and out_word field offsets.
package secded_pkg;

    localparam int P_DEFAULT = 4;

    function automatic int secded_cw_w(int p);
        return 1 << p;
    endfunction

    function automatic int secded_data_w(int p);
        return (1 << p) - p - 1;
    endfunction

    localparam int DATA_W = secded_data_w(P_DEFAULT);
    localparam int CW_W   = secded_cw_w(P_DEFAULT);

    // Data bits fill every non-power-of-two position above 0, lowest index first.
    function automatic int data_pos(int p, int idx);
        int pos;
        int n;
        pos = 0;
        n   = 0;
        for (int k = 1; k < (1 << p); k++) begin
            if ((k & (k - 1)) != 0) begin
                n++;
                if (n == idx && pos == 0) pos = k;
            end
        end
        return pos;
    endfunction

    localparam int DATA_OFS = 0;

    function automatic int dbl_ofs(int p);
        return secded_cw_w(p) - 1;
    endfunction

    function automatic int sgl_ofs(int p);
        return secded_cw_w(p) - 2;
    endfunction

    function automatic logic [15:0] sat_inc(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity of a codeword.
module secded_syndrome
    import secded_pkg::*;
#(
    parameter int P = P_DEFAULT
) (
    input  logic [secded_cw_w(P)-1:0] cw,
    output logic [P-1:0]              s,
    output logic                      q
);

    always_comb begin
        s = '0;
        for (int i = 1; i < secded_cw_w(P); i++) begin
            if (cw[i]) s = s ^ i[P-1:0];
        end
        q = ^cw;
    end

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage valid/ready SECDED decoder with optional correction and saturating
// word / single / double error counters.
module secded_stream_decoder
    import secded_pkg::*;
#(
    parameter int P = P_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [secded_cw_w(P)-1:0] in_cw,
    input  logic                      detect_only,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [secded_cw_w(P)-1:0] out_word,
    output logic [15:0]               cnt_total,
    output logic [15:0]               cnt_sgl,
    output logic [15:0]               cnt_dbl,
    input  logic                      clr_cnt
);

    localparam int CW_BITS   = secded_cw_w(P);
    localparam int DATA_BITS = secded_data_w(P);
    localparam int SGL_BIT   = sgl_ofs(P);
    localparam int DBL_BIT   = dbl_ofs(P);

    logic [P-1:0]         syn_s;
    logic                 syn_q;

    logic                 s1_valid;
    logic [CW_BITS-1:0]   s1_cw;
    logic [P-1:0]         s1_s;
    logic                 s1_q;
    logic                 s1_detect;

    logic                 s2_valid;
    logic                 s2_ready;
    logic                 out_hs;

    logic [CW_BITS-1:0]   fixed_cw;
    logic [DATA_BITS-1:0] data;
    logic [CW_BITS-1:0]   dec_word;

    secded_syndrome #(.P(P)) u_syndrome (
        .cw (in_cw),
        .s  (syn_s),
        .q  (syn_q)
    );

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    // Masked during reset so a word sitting in S2 cannot handshake on that cycle.
    assign out_valid = s2_valid && !reset;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        fixed_cw = s1_cw;
        if (s1_q && !s1_detect) fixed_cw[s1_s] = ~s1_cw[s1_s];
    end

    for (genvar i = 1; i <= DATA_BITS; i++) begin : g_data
        assign data[i-1] = fixed_cw[data_pos(P, i)];
    end

    always_comb begin
        dec_word                       = '0;
        dec_word[DATA_OFS +: DATA_BITS] = data;
        dec_word[SGL_BIT]              = s1_q;
        dec_word[DBL_BIT]              = !s1_q && (s1_s != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_cw     <= '0;
            s1_s      <= '0;
            s1_q      <= 1'b0;
            s1_detect <= 1'b0;
            s2_valid  <= 1'b0;
            out_word  <= '0;
            cnt_total <= '0;
            cnt_sgl   <= '0;
            cnt_dbl   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_cw     <= in_cw;
                    s1_s      <= syn_s;
                    s1_q      <= syn_q;
                    s1_detect <= detect_only;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) out_word <= dec_word;
            end
            if (clr_cnt) begin
                cnt_total <= '0;
                cnt_sgl   <= '0;
                cnt_dbl   <= '0;
            end else if (out_hs) begin
                cnt_total <= sat_inc(cnt_total);
                if (out_word[SGL_BIT]) cnt_sgl <= sat_inc(cnt_sgl);
                if (out_word[DBL_BIT]) cnt_dbl <= sat_inc(cnt_dbl);
            end
        end
    end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Self-checking bench: directed P=4/P=5 vectors, random backpressure stream vs a
// behavioural decoder model, counter clear priority and mid-stream reset.
module tb_secded_stream_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        detect_only;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_valid4, in_ready4, out_valid4;
    logic [15:0] in_cw4, out_word4, cnt_total4, cnt_sgl4, cnt_dbl4;

    logic        in_valid5, in_ready5, out_valid5;
    logic [31:0] in_cw5, out_word5;
    logic [15:0] cnt_total5, cnt_sgl5, cnt_dbl5;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [15:0] e_tot = '0, e_sgl = '0, e_dbl = '0;

    always #5 clk = ~clk;

    secded_stream_decoder #(.P(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_cw(in_cw4), .detect_only(detect_only), .out_valid(out_valid4),
        .out_ready(out_ready), .out_word(out_word4), .cnt_total(cnt_total4),
        .cnt_sgl(cnt_sgl4), .cnt_dbl(cnt_dbl4), .clr_cnt(clr_cnt)
    );

    secded_stream_decoder #(.P(5)) u5 (
        .clk(clk), .reset(reset), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_cw(in_cw5), .detect_only(detect_only), .out_valid(out_valid5),
        .out_ready(out_ready), .out_word(out_word5), .cnt_total(cnt_total5),
        .cnt_sgl(cnt_sgl5), .cnt_dbl(cnt_dbl5), .clr_cnt(clr_cnt)
    );

    task automatic chk(logic [63:0] obs, logic [63:0] exp, string tag);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decoder described directly from the code rules: syndrome/parity by index
    // arithmetic, classification, optional flip, then data gathered by position.
    function automatic logic [63:0] ref_decode(int p, logic [63:0] cw_in, bit det);
        logic [63:0] cw;
        logic [63:0] res;
        int n, s, q, k;
        cw  = cw_in;
        res = '0;
        n   = 1 << p;
        s   = 0;
        q   = 0;
        for (int i = 0; i < n; i++) begin
            if (cw[i]) begin
                q = q ^ 1;
                s = s ^ i;
            end
        end
        if (q == 1 && !det) cw[s] = ~cw[s];
        k = 0;
        for (int pos = 1; pos < n; pos++) begin
            if ($countones(pos) != 1) begin
                res[k] = cw[pos];
                k++;
            end
        end
        res[n-2] = (q == 1);
        res[n-1] = (q == 0 && s != 0);
        return res;
    endfunction

    task automatic count_word(logic [15:0] w);
        if (e_tot != 16'hFFFF) e_tot++;
        if (w[14] && e_sgl != 16'hFFFF) e_sgl++;
        if (w[15] && e_dbl != 16'hFFFF) e_dbl++;
    endtask

    // One word through an idle pipe with out_ready=1; checks exact 2-cycle latency.
    task automatic send_check(int p, logic [63:0] cw, bit det, logic [63:0] exp, string tag);
        @(negedge clk);
        detect_only = det;
        if (p == 4) begin in_valid4 = 1'b1; in_cw4 = cw[15:0]; end
        else        begin in_valid5 = 1'b1; in_cw5 = cw[31:0]; end
        #1;
        chk(64'((p == 4) ? in_ready4 : in_ready5), 64'd1, {tag, "_in_ready"});
        @(negedge clk);
        in_valid4 = 1'b0;
        in_valid5 = 1'b0;
        #1;
        chk(64'((p == 4) ? out_valid4 : out_valid5), 64'd0, {tag, "_lat1_valid"});
        @(negedge clk);
        #1;
        chk(64'((p == 4) ? out_valid4 : out_valid5), 64'd1, {tag, "_lat2_valid"});
        chk((p == 4) ? 64'(out_word4) : 64'(out_word5), exp, tag);
        if (p == 4) count_word(exp[15:0]);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] exp_w;
        logic [15:0] held;
        bit          stall, accepted;
        int          sent, got;

        reset       = 1'b1;
        detect_only = 1'b0;
        out_ready   = 1'b1;
        clr_cnt     = 1'b0;
        in_valid4   = 1'b0;
        in_cw4      = '0;
        in_valid5   = 1'b0;
        in_cw5      = '0;

        repeat (3) @(negedge clk);
        #1;
        chk(64'(out_valid4), 64'd0, "rst_out_valid");
        chk(64'(out_word4), 64'd0, "rst_out_word");
        chk(64'({cnt_total4, cnt_sgl4, cnt_dbl4}), 64'd0, "rst_counters");
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk(64'(in_ready4), 64'd1, "post_rst_in_ready");

        send_check(4, 64'hFFFF, 1'b0, 64'h07FF, "clean_ffff");
        send_check(4, 64'h0000, 1'b0, 64'h0000, "clean_0000");
        send_check(4, 64'h0020, 1'b0, 64'h4000, "sgl_bit5");
        send_check(4, 64'h0001, 1'b0, 64'h4000, "sgl_p0");
        send_check(4, 64'hFDFF, 1'b0, 64'h47FF, "sgl_bit9");
        send_check(4, 64'h0008, 1'b1, 64'h4001, "detect_only_d1");
        send_check(4, 64'h0220, 1'b0, 64'h8012, "dbl_bits5_9");
        @(negedge clk);
        #1;
        chk(64'(cnt_total4), 64'(e_tot), "dir_cnt_total");
        chk(64'(cnt_sgl4), 64'(e_sgl), "dir_cnt_sgl");
        chk(64'(cnt_dbl4), 64'(e_dbl), "dir_cnt_dbl");

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        e_tot = '0; e_sgl = '0; e_dbl = '0;
        #1;
        chk(64'({cnt_total4, cnt_sgl4, cnt_dbl4}), 64'd0, "clr_idle");

        // Random stream with random backpressure.
        sent = 0; got = 0; stall = 1'b0; accepted = 1'b0; held = '0;
        for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
            @(negedge clk);
            if (stall) begin
                chk(64'(out_valid4), 64'd1, "stall_valid_held");
                chk(64'(out_word4), 64'(held), "stall_word_held");
            end
            if (accepted) in_valid4 = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid4 && sent < 10) begin
                in_cw4      = 16'($urandom);
                detect_only = ($urandom_range(0, 3) == 0);
                in_valid4   = 1'b1;
            end
            #1;
            accepted = in_valid4 && in_ready4;
            if (accepted) begin
                q.push_back(ref_decode(4, 64'(in_cw4), detect_only));
                sent++;
            end
            if (out_valid4 && out_ready) begin
                exp_w = (q.size() > 0) ? q.pop_front() : 'x;
                chk(64'(out_word4), exp_w, "stream_order");
                count_word(exp_w[15:0]);
                got++;
                stall = 1'b0;
            end else begin
                stall = out_valid4;
                held  = out_word4;
            end
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        out_ready = 1'b1;
        #1;
        chk(64'(got), 64'd10, "stream_received");
        chk(64'(cnt_total4), 64'd10, "stream_cnt_total");
        chk(64'(cnt_sgl4), 64'(e_sgl), "stream_cnt_sgl");
        chk(64'(cnt_dbl4), 64'(e_dbl), "stream_cnt_dbl");
        chk(64'(out_valid4), 64'd0, "stream_no_extra");

        // Clear coincident with an output handshake.
        in_cw4    = 16'h0020;
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        #1;
        chk(64'(out_valid4), 64'd1, "clr_hs_word_ready");
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        chk(64'(out_valid4), 64'd0, "clr_hs_consumed");
        chk(64'({cnt_total4, cnt_sgl4, cnt_dbl4}), 64'd0, "clr_hs_counters");

        // P=5 single-error correction, then reset with two words in flight.
        send_check(5, 64'h0002_0000, 1'b0, 64'h4000_0000, "p5_sgl_bit17");
        @(negedge clk);
        #1;
        chk(64'(cnt_total5), 64'd1, "p5_cnt_total");
        out_ready   = 1'b0;
        detect_only = 1'b0;
        in_cw5      = $urandom;
        in_valid5   = 1'b1;
        @(negedge clk);
        in_cw5 = $urandom;
        @(negedge clk);
        in_valid5 = 1'b0;
        #1;
        chk(64'(out_valid5), 64'd1, "p5_inflight_valid");
        out_ready = 1'b1;
        reset     = 1'b1;
        #1;
        chk(64'(out_valid5), 64'd0, "p5_no_hs_on_reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk(64'({cnt_total5, cnt_sgl5, cnt_dbl5}), 64'd0, "p5_rst_counters");
        chk(64'(in_ready5), 64'd1, "p5_rst_in_ready");
        repeat (3) begin
            @(negedge clk);
            #1;
            chk(64'(out_valid5), 64'd0, "p5_rst_discard");
        end
        chk(64'(cnt_total5), 64'd0, "p5_rst_cnt_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
